// File: rtl/control_sequencer.sv
// control_sequencer: queues {opcode, repeat} instructions and issues them as a
// registered one-hot control word, holding each word for rpt+1 cycles. A
// skip-class opcode issued with sf=1 discards the following instruction.
module control_sequencer #(
    parameter int OP_W     = 4,
    parameter int RPT_W    = 3,
    parameter int DEPTH    = 4,
    parameter int SKIP_OP0 = 8,
    parameter int SKIP_OP1 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    input  logic [OP_W+RPT_W-1:0] instr_in,
    output logic                  instr_ready,
    input  logic                  hold,
    input  logic                  sf,
    output logic [2**OP_W-1:0]    ctrl,
    output logic                  ctrl_valid,
    output logic                  busy,
    output logic                  skipped
);

    localparam int CW = 2**OP_W;
    localparam int IW = OP_W + RPT_W;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    // ISSUE is the first cycle of an instruction (or the single cycle of a
    // discarded one); REPEAT covers the remaining rpt cycles.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [AW:0]       count_q, count_d;
    logic              notFull_q;
    logic [CW-1:0]     ctrl_q, ctrl_d;
    logic              ctrlValid_q, ctrlValid_d;
    logic              skipped_q, skipped_d;
    logic [RPT_W-1:0]  rptCount_q, rptCount_d;
    logic              skipClass_q, skipClass_d;
    logic              skipArmed_q, skipArmed_d;

    logic              push;
    logic              pop;
    logic              lastCycle;
    logic              armNow;
    logic [OP_W-1:0]   headOp;
    logic [RPT_W-1:0]  headRpt;
    logic              headIsSkip;

    assign push       = instr_valid && notFull_q && !rst;
    assign lastCycle  = (state_q != IDLE) && (rptCount_q == '0);
    assign pop        = (count_q != '0) && !hold && ((state_q == IDLE) || lastCycle);
    assign headOp     = mem[rdPtr_q][IW-1:RPT_W];
    assign headRpt    = mem[rdPtr_q][RPT_W-1:0];
    assign headIsSkip = (int'(headOp) == SKIP_OP0) || (int'(headOp) == SKIP_OP1);
    // The first ctrl cycle of a real (not discarded) skip-class instruction
    // with sf high arms the skip; discard cycles carry ctrl_valid=0 so they
    // can never chain a further skip.
    assign armNow     = (state_q == ISSUE) && ctrlValid_q && skipClass_q && sf;

    // Queue storage: written at the tail on every handshake, not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= instr_in;
        end
    end

    // Occupancy next-value; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue pointers, occupancy and the registered not-full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            notFull_q <= 1'b1;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q   <= count_d;
            notFull_q <= (count_d != FullCount);
        end
    end

    // Next-state and output-register logic for the issue FSM.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        ctrlValid_d = ctrlValid_q;
        skipped_d   = skipped_q;
        rptCount_d  = rptCount_q;
        skipClass_d = skipClass_q;
        skipArmed_d = skipArmed_q;

        if (armNow) begin
            skipArmed_d = 1'b1;
        end

        if (!hold) begin
            if ((state_q != IDLE) && (rptCount_q != '0)) begin
                rptCount_d = rptCount_q - RPT_W'(1);
                state_d    = REPEAT;
            end else if (pop) begin
                state_d = ISSUE;
                if (skipArmed_q || armNow) begin
                    skipArmed_d = 1'b0;
                    ctrl_d      = '0;
                    ctrlValid_d = 1'b0;
                    skipped_d   = 1'b1;
                    rptCount_d  = '0;
                    skipClass_d = 1'b0;
                end else begin
                    ctrl_d      = CW'(1) << headOp;
                    ctrlValid_d = 1'b1;
                    skipped_d   = 1'b0;
                    rptCount_d  = headRpt;
                    skipClass_d = headIsSkip;
                end
            end else begin
                state_d     = IDLE;
                ctrl_d      = '0;
                ctrlValid_d = 1'b0;
                skipped_d   = 1'b0;
                rptCount_d  = '0;
                skipClass_d = 1'b0;
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            ctrlValid_q <= 1'b0;
            skipped_q   <= 1'b0;
            rptCount_q  <= '0;
            skipClass_q <= 1'b0;
            skipArmed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            ctrlValid_q <= ctrlValid_d;
            skipped_q   <= skipped_d;
            rptCount_q  <= rptCount_d;
            skipClass_q <= skipClass_d;
            skipArmed_q <= skipArmed_d;
        end
    end

    assign instr_ready = notFull_q;
    assign ctrl        = ctrl_q;
    assign ctrl_valid  = ctrlValid_q;
    assign skipped     = skipped_q;
    assign busy        = (count_q != '0) || ctrlValid_q || (state_q != IDLE);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: default-parameter instance plus a
// narrow OP_W=3/RPT_W=2/DEPTH=8 instance for the pointer-wrap scenario.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [6:0]  instr_in;
    logic        instr_ready;
    logic        hold;
    logic        sf;
    logic [15:0] ctrl;
    logic        ctrl_valid;
    logic        busy;
    logic        skipped;

    logic        p_instr_valid;
    logic [4:0]  p_instr_in;
    logic        p_instr_ready;
    logic        p_hold;
    logic        p_sf;
    logic [7:0]  p_ctrl;
    logic        p_ctrl_valid;
    logic        p_busy;
    logic        p_skipped;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp;
    logic [11:0] pExp;
    logic [2:0]  warmOps [3] = '{3'd6, 3'd1, 3'd3};
    logic [2:0]  fillOps [8] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd6, 3'd1, 3'd4, 3'd3};

    control_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready), .hold(hold), .sf(sf), .ctrl(ctrl),
        .ctrl_valid(ctrl_valid), .busy(busy), .skipped(skipped)
    );

    control_sequencer #(.OP_W(3), .RPT_W(2), .DEPTH(8)) dutP (
        .clk(clk), .rst(rst), .instr_valid(p_instr_valid), .instr_in(p_instr_in),
        .instr_ready(p_instr_ready), .hold(p_hold), .sf(p_sf), .ctrl(p_ctrl),
        .ctrl_valid(p_ctrl_valid), .busy(p_busy), .skipped(p_skipped)
    );

    always #5 clk = ~clk;

    // Status word: {ctrl, ctrl_valid, skipped, busy, instr_ready}
    function automatic logic [19:0] status();
        return {ctrl, ctrl_valid, skipped, busy, instr_ready};
    endfunction

    function automatic logic [11:0] pStatus();
        return {p_ctrl, p_ctrl_valid, p_skipped, p_busy, p_instr_ready};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pushInstr(input logic [3:0] op, input logic [2:0] r);
        instr_valid = 1'b1;
        instr_in    = {op, r};
        cycle();
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b1;
        instr_in = {4'd10, 3'd0};
        cycle();
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL reset_state: got %h expected %h", status(), exp); end
        checks++; pExp = {8'h00, 4'b0001};
        if (pStatus() !== pExp) begin errors++; $display("[TB] FAIL reset_state_p: got %h expected %h", pStatus(), pExp); end
        rst = 1'b0;
        instr_valid = 1'b0;
        cycle();
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL reset_handshake_ignored: got %h expected %h", status(), exp); end
    endtask

    task automatic test_single_op();
        pushInstr(4'd10, 3'd0);
        checks++; exp = {16'h0000, 4'b0011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL single_queued: got %h expected %h", status(), exp); end
        cycle();
        checks++; exp = {16'h0400, 4'b1011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL single_issue: got %h expected %h", status(), exp); end
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL single_done: got %h expected %h", status(), exp); end
    endtask

    task automatic test_repeat();
        pushInstr(4'd5, 3'd3);
        pushInstr(4'd6, 3'd0);
        for (int i = 0; i < 4; i++) begin
            checks++; exp = {16'h0020, 4'b1011};
            if (status() !== exp) begin errors++; $display("[TB] FAIL repeat_cycle%0d: got %h expected %h", i, status(), exp); end
            cycle();
        end
        checks++; exp = {16'h0040, 4'b1011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL repeat_back_to_back: got %h expected %h", status(), exp); end
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL repeat_done: got %h expected %h", status(), exp); end
    endtask

    task automatic test_hold_freeze();
        pushInstr(4'd3, 3'd1);
        cycle();
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; exp = {16'h0008, 4'b1011};
            if (status() !== exp) begin errors++; $display("[TB] FAIL hold_frozen%0d: got %h expected %h", i, status(), exp); end
        end
        hold = 1'b0;
        cycle();
        checks++; exp = {16'h0008, 4'b1011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL hold_repeat_resume: got %h expected %h", status(), exp); end
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL hold_done: got %h expected %h", status(), exp); end
    endtask

    task automatic test_full_queue();
        logic [15:0] order [4] = '{16'h0002, 16'h0004, 16'h0008, 16'h0010};
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (instr_ready !== (i < 4)) begin errors++; $display("[TB] FAIL full_ready%0d: got %b expected %b", i, instr_ready, (i < 4)); end
            instr_valid = 1'b1;
            instr_in = (i < 4) ? {4'(i + 1), 3'd0} : {4'd15, 3'd0};
            cycle();
        end
        instr_valid = 1'b0;
        checks++; exp = {16'h0000, 4'b0010};
        if (status() !== exp) begin errors++; $display("[TB] FAIL full_held: got %h expected %h", status(), exp); end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++; exp = {order[i], 4'b1011};
            if (status() !== exp) begin errors++; $display("[TB] FAIL full_order%0d: got %h expected %h", i, status(), exp); end
        end
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL full_done: got %h expected %h", status(), exp); end
    endtask

    task automatic test_skip(input logic sfVal, input logic [3:0] op1, input logic [3:0] op2,
                             input logic [19:0] exp2, input logic [19:0] exp3);
        sf = sfVal;
        instr_valid = 1'b1;
        instr_in = {4'd8, 3'd0};
        cycle();
        instr_in = {op1, 3'd0};
        cycle();
        checks++; exp = {16'h0100, 4'b1011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL skip_first sf=%b: got %h expected %h", sfVal, status(), exp); end
        instr_in = {op2, 3'd0};
        cycle();
        instr_valid = 1'b0;
        checks++;
        if (status() !== exp2) begin errors++; $display("[TB] FAIL skip_second sf=%b: got %h expected %h", sfVal, status(), exp2); end
        cycle();
        checks++;
        if (status() !== exp3) begin errors++; $display("[TB] FAIL skip_third sf=%b: got %h expected %h", sfVal, status(), exp3); end
        cycle();
        sf = 1'b0;
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL skip_done sf=%b: got %h expected %h", sfVal, status(), exp); end
    endtask

    task automatic test_skip_armed();
        sf = 1'b1;
        pushInstr(4'd9, 3'd0);
        cycle();
        checks++; exp = {16'h0200, 4'b1011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL armed_issue: got %h expected %h", status(), exp); end
        cycle();
        sf = 1'b0;
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL armed_idle: got %h expected %h", status(), exp); end
        pushInstr(4'd2, 3'd5);
        cycle();
        checks++; exp = {16'h0000, 4'b0111};
        if (status() !== exp) begin errors++; $display("[TB] FAIL armed_discard: got %h expected %h", status(), exp); end
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL armed_pulse_end: got %h expected %h", status(), exp); end
        pushInstr(4'd3, 3'd0);
        cycle();
        checks++; exp = {16'h0008, 4'b1011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL armed_next_issue: got %h expected %h", status(), exp); end
        cycle();
    endtask

    task automatic test_reset_mid_repeat();
        pushInstr(4'd7, 3'd7);
        pushInstr(4'd2, 3'd0);
        cycle();
        cycle();
        checks++; exp = {16'h0080, 4'b1011};
        if (status() !== exp) begin errors++; $display("[TB] FAIL midrst_third_cycle: got %h expected %h", status(), exp); end
        rst = 1'b1;
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL midrst_cleared: got %h expected %h", status(), exp); end
        rst = 1'b0;
        cycle();
        cycle();
        checks++; exp = {16'h0000, 4'b0001};
        if (status() !== exp) begin errors++; $display("[TB] FAIL midrst_queue_empty: got %h expected %h", status(), exp); end
    endtask

    task automatic test_param_sweep();
        logic [7:0] oh;
        p_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p_instr_valid = 1'b1;
            p_instr_in = {warmOps[i], 2'b00};
            cycle();
        end
        p_instr_valid = 1'b0;
        p_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            oh = 8'd1 << warmOps[i];
            checks++; pExp = {oh, 4'b1011};
            if (pStatus() !== pExp) begin errors++; $display("[TB] FAIL sweep_warm%0d: got %h expected %h", i, pStatus(), pExp); end
        end
        cycle();
        p_hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (p_instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL sweep_ready%0d: got %b expected 1", i, p_instr_ready); end
            p_instr_valid = 1'b1;
            p_instr_in = {fillOps[i], 2'b00};
            cycle();
        end
        p_instr_valid = 1'b0;
        checks++; pExp = {8'h00, 4'b0010};
        if (pStatus() !== pExp) begin errors++; $display("[TB] FAIL sweep_full: got %h expected %h", pStatus(), pExp); end
        p_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            oh = 8'd1 << fillOps[i];
            checks++; pExp = {oh, 4'b1011};
            if (pStatus() !== pExp) begin errors++; $display("[TB] FAIL sweep_order%0d: got %h expected %h", i, pStatus(), pExp); end
        end
        cycle();
        checks++; pExp = {8'h00, 4'b0001};
        if (pStatus() !== pExp) begin errors++; $display("[TB] FAIL sweep_done: got %h expected %h", pStatus(), pExp); end
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_in = '0;
        hold = 1'b0;
        sf = 1'b0;
        p_instr_valid = 1'b0;
        p_instr_in = '0;
        p_hold = 1'b0;
        p_sf = 1'b0;

        test_reset();
        test_single_op();
        test_repeat();
        test_hold_freeze();
        test_full_queue();
        test_skip(1'b1, 4'd0, 4'd1, {16'h0000, 4'b0111}, {16'h0002, 4'b1011});
        test_skip(1'b0, 4'd0, 4'd1, {16'h0001, 4'b1011}, {16'h0002, 4'b1011});
        test_skip(1'b1, 4'd9, 4'd4, {16'h0000, 4'b0111}, {16'h0010, 4'b1011});
        test_skip_armed();
        test_reset_mid_repeat();
        test_param_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter OP_W, default 4, meaning opcode width; the one-hot control vector width is 2**OP_W.
REQ-002 The block SHALL have parameter RPT_W, default 3, meaning repeat-count field width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries; DEPTH SHALL be a power of two and at least 2.
REQ-004 The block SHALL have parameter SKIP_OP0, default 8, meaning the first skip-class opcode (SNZA).
REQ-005 The block SHALL have parameter SKIP_OP1, default 9, meaning the second skip-class opcode (SNZS).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port instr_valid, input, 1 bit: instr_in is valid this cycle.
REQ-009 The block SHALL have port instr_in, input, OP_W+RPT_W bits: {opcode[OP_W-1:0], rpt[RPT_W-1:0]}, opcode in the MSBs.
REQ-010 The block SHALL have port instr_ready, output, 1 bit: the queue can accept an instruction.
REQ-011 The block SHALL have port hold, input, 1 bit: freeze issue (external stall).
REQ-012 The block SHALL have port sf, input, 1 bit: skip flag, sampled on the first cycle of a skip-class opcode.
REQ-013 The block SHALL have port ctrl, output, 2**OP_W bits: registered one-hot control; bit k is asserted for opcode k.
REQ-014 The block SHALL have port ctrl_valid, output, 1 bit: ctrl carries an issued instruction.
REQ-015 The block SHALL have port busy, output, 1 bit: the queue is non-empty or an instruction is executing.
REQ-016 The block SHALL have port skipped, output, 1 bit: a one-cycle pulse when an instruction is discarded by the skip rule.

Function
REQ-017 A handshake SHALL occur when instr_valid and instr_ready are both high at a rising edge; the instruction is written to the queue tail.
REQ-018 instr_ready SHALL equal the registered "not full" state; when the queue is full, a same-cycle pop SHALL NOT make the queue ready in that cycle.
REQ-019 The FSM SHALL have states IDLE, ISSUE and REPEAT.
REQ-020 In IDLE: if the queue is non-empty and hold=0, the FSM SHALL pop the head, load ctrl with the one-hot opcode, set ctrl_valid=1, load the repeat counter with rpt, and go to ISSUE.
REQ-021 Minimum latency from handshake to ctrl_valid SHALL be 1 cycle: instruction accepted at edge t gives ctrl asserted after edge t+1.
REQ-022 An issued instruction SHALL hold ctrl for rpt+1 consecutive cycles; the REPEAT state decrements the counter each cycle and is entered whenever rpt>0.
REQ-023 On the last cycle of an instruction: if the queue is non-empty and hold=0, the FSM SHALL issue the next instruction back-to-back with no bubble; otherwise it SHALL return to IDLE with ctrl=0 and ctrl_valid=0.
REQ-024 While hold=1, ctrl, ctrl_valid, the repeat counter and the FSM state SHALL freeze, and no pop SHALL occur; pushes SHALL continue.
REQ-025 Skip rule: if the issued opcode equals SKIP_OP0 or SKIP_OP1 and sf=1 on its first ctrl cycle, the next instruction popped SHALL be discarded. For that instruction: no ctrl, ctrl_valid=0, skipped=1 for one cycle, and it consumes one cycle regardless of its rpt.
REQ-026 If the queue is empty when a skip is pending, the skip SHALL remain armed until the next instruction arrives.
REQ-027 A skip-class instruction that is itself discarded SHALL NOT arm a further skip.
REQ-028 Queue pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; an occupancy counter of log2(DEPTH)+1 bits SHALL distinguish full from empty.
REQ-029 Simultaneous push and pop on a non-full, non-empty queue SHALL leave occupancy unchanged.
REQ-030 Simultaneous push and pop on an empty queue SHALL NOT occur, because a pop requires a stored entry.
REQ-031 busy SHALL be 1 when occupancy>0, or ctrl_valid=1, or the FSM is not in IDLE.
REQ-032 ctrl SHALL never have more than one bit set.

Reset
REQ-033 On rst=1 at a rising edge, the block SHALL set: FSM=IDLE, occupancy=0, pointers=0, repeat counter=0, skip armed=0, ctrl=0, ctrl_valid=0, skipped=0, busy=0, instr_ready=1.
REQ-034 A reset asserted mid-instruction or mid-repeat SHALL take effect at that edge, and all queued instructions SHALL be lost.
REQ-035 A handshake in a cycle with rst=1 SHALL be ignored.

Verification
REQ-036 Single op: push {opcode=10, rpt=0} -> after 1 edge, ctrl=16'h0400 and ctrl_valid=1 for exactly 1 cycle; then ctrl=0 and busy=0.
REQ-037 Repeat: push {opcode=5, rpt=3} -> ctrl=16'h0020 for 4 consecutive cycles; a queued {opcode=6, rpt=0} then follows with no bubble.
REQ-038 Full queue: hold=1, push 5 instructions -> first 4 accepted, instr_ready=0 on the 5th; release hold -> all 4 issue in FIFO order.
REQ-039 Skip: push opcode 8 with sf=1, then opcode 0, then opcode 1 -> ctrl sequence is bit8, bubble with skipped=1, bit1. Same sequence with sf=0 -> bit8, bit0, bit1.
REQ-040 Reset mid-repeat: issue {opcode=7, rpt=7}, assert rst on the 3rd ctrl cycle -> next cycle ctrl=0, busy=0, instr_ready=1, and the queue is empty.
REQ-041 Parameter sweep: OP_W=3, RPT_W=2, DEPTH=8 -> one-hot width is 8; the pointer wraps after 8 pushes with FIFO order preserved.
